// File: rtl/beat_scheduler_pkg.sv
// Shared constants for the beat scheduler: legal tempos, their beat periods
// in 6 kHz ticks, and the lock-state type.
package beat_scheduler_pkg;

  localparam int TICK_HZ = 6000;
  localparam int PHASE_W = 13;

  localparam logic [7:0] TEMPO_60  = 8'd60;
  localparam logic [7:0] TEMPO_90  = 8'd90;
  localparam logic [7:0] TEMPO_120 = 8'd120;
  localparam logic [7:0] TEMPO_180 = 8'd180;
  localparam logic [7:0] TEMPO_210 = 8'd210;
  localparam logic [7:0] TEMPO_240 = 8'd240;

  // Ticks per beat; 210 BPM truncates 1714.28 down to 1714.
  localparam logic [PHASE_W-1:0] PERIOD_60  = 13'd6000;
  localparam logic [PHASE_W-1:0] PERIOD_90  = 13'd4000;
  localparam logic [PHASE_W-1:0] PERIOD_120 = 13'd3000;
  localparam logic [PHASE_W-1:0] PERIOD_180 = 13'd2000;
  localparam logic [PHASE_W-1:0] PERIOD_210 = 13'd1714;
  localparam logic [PHASE_W-1:0] PERIOD_240 = 13'd1500;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_e;

endpackage

// File: rtl/beat_scheduler_lut.sv
// Combinational tempo-to-period lookup; anything outside the legal tempo set
// reports legal=0 and a zero period.
module tempo_period_lut
  import beat_scheduler_pkg::*;
(
  input  logic [7:0]         tempo,
  output logic [PHASE_W-1:0] period,
  output logic               legal
);

  always_comb begin
    period = '0;
    legal  = 1'b1;
    case (tempo)
      TEMPO_60:  period = PERIOD_60;
      TEMPO_90:  period = PERIOD_90;
      TEMPO_120: period = PERIOD_120;
      TEMPO_180: period = PERIOD_180;
      TEMPO_210: period = PERIOD_210;
      TEMPO_240: period = PERIOD_240;
      default:   legal  = 1'b0;
    endcase
  end

endmodule

// File: rtl/beat_scheduler.sv
// Beat scheduler: adopts a tempo after AGREE_N matching estimates, then paces
// beat/bar pulses off the tick timebase with onset-driven phase correction.
module beat_scheduler
  import beat_scheduler_pkg::*;
#(
  parameter int AGREE_N = 4,
  parameter int BAR_LEN = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic [7:0]         tempo_in,
  input  logic               tempo_valid,
  input  logic               onset,
  output logic [7:0]         tempo_locked,
  output logic               locked,
  output logic               beat,
  output logic [1:0]         beat_index,
  output logic               bar,
  output logic [PHASE_W-1:0] phase
);

  localparam int AGREE_W = (AGREE_N < 2) ? 1 : $clog2(AGREE_N + 1);

  lock_state_e        state_q, state_d;
  logic [7:0]         tempo_q, tempo_d, cand_q, cand_d;
  logic [AGREE_W-1:0] agree_q, agree_d;
  logic [PHASE_W-1:0] period_q, period_d, phase_q, phase_d;
  logic [1:0]         index_q, index_d, index_next;
  logic               beat_q, beat_d, bar_q, bar_d;
  logic [PHASE_W-1:0] lut_period, window;
  logic               lut_legal, strobe, adopt, wrap, early, late;

  tempo_period_lut u_lut (
    .tempo  (tempo_in),
    .period (lut_period),
    .legal  (lut_legal)
  );

  // The correction window is an eighth of a beat on either side of the wrap.
  assign window     = period_q >> 3;
  assign wrap       = tick && (phase_q == period_q - PHASE_W'(1));
  assign early      = onset && (phase_q >= period_q - window);
  assign late       = onset && (phase_q != '0) && (phase_q <= window);
  assign index_next = (index_q == 2'(BAR_LEN - 1)) ? 2'd0 : index_q + 2'd1;
  assign strobe     = tempo_valid && lut_legal;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= UNLOCKED;
      tempo_q  <= '0;
      cand_q   <= '0;
      agree_q  <= '0;
      period_q <= '0;
      phase_q  <= '0;
      index_q  <= '0;
      beat_q   <= 1'b0;
      bar_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      tempo_q  <= tempo_d;
      cand_q   <= cand_d;
      agree_q  <= agree_d;
      period_q <= period_d;
      phase_q  <= phase_d;
      index_q  <= index_d;
      beat_q   <= beat_d;
      bar_q    <= bar_d;
    end
  end

  // Adoption outranks tick/onset; a tick wrap absorbs a coincident onset.
  always_comb begin
    state_d  = state_q;
    tempo_d  = tempo_q;
    cand_d   = cand_q;
    agree_d  = agree_q;
    period_d = period_q;
    phase_d  = phase_q;
    index_d  = index_q;
    beat_d   = 1'b0;
    bar_d    = 1'b0;
    adopt    = 1'b0;

    if (strobe) begin
      if (tempo_in == cand_q) begin
        if (agree_q != AGREE_W'(AGREE_N))
          agree_d = agree_q + AGREE_W'(1);
      end else begin
        cand_d  = tempo_in;
        agree_d = AGREE_W'(1);
      end
      adopt = (agree_d == AGREE_W'(AGREE_N)) && (cand_d != tempo_q);
    end

    if (adopt) begin
      state_d  = LOCKED;
      tempo_d  = cand_d;
      period_d = lut_period;
      phase_d  = '0;
      index_d  = '0;
    end else if (state_q == LOCKED) begin
      if (wrap || early) begin
        phase_d = '0;
        beat_d  = 1'b1;
        index_d = index_next;
        bar_d   = (index_next == 2'd0);
      end else if (late) begin
        phase_d = '0;
      end else if (tick) begin
        phase_d = phase_q + PHASE_W'(1);
      end
    end
  end

  assign tempo_locked = tempo_q;
  assign locked       = (state_q == LOCKED);
  assign beat         = beat_q;
  assign bar          = bar_q;
  assign beat_index   = index_q;
  assign phase        = phase_q;

endmodule

// File: tb/tb_beat_scheduler.sv
// Self-checking bench for beat_scheduler: a tempo/beat reference model checked
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_beat_scheduler;

  localparam int AGREE_N = 4;
  localparam int BAR_LEN = 4;
  localparam int TICK_HZ = 6000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        tick = 1'b0;
  logic        tempo_valid = 1'b0;
  logic        onset = 1'b0;
  logic [7:0]  tempo_in = 8'd0;
  logic [7:0]  tempo_locked;
  logic        locked, beat, bar;
  logic [1:0]  beat_index;
  logic [12:0] phase;

  int total = 0;
  int bad   = 0;
  int legal_list [6] = '{60, 90, 120, 180, 210, 240};

  int m_tempo = 0, m_period = 0, m_phase = 0, m_idx = 0, m_cand = 0, m_agree = 0;
  bit m_locked = 0, m_beat = 0, m_bar = 0;

  always #5 clk = ~clk;

  beat_scheduler #(.AGREE_N(AGREE_N), .BAR_LEN(BAR_LEN)) dut (
    .clk          (clk),
    .reset        (reset),
    .tick         (tick),
    .tempo_in     (tempo_in),
    .tempo_valid  (tempo_valid),
    .onset        (onset),
    .tempo_locked (tempo_locked),
    .locked       (locked),
    .beat         (beat),
    .beat_index   (beat_index),
    .bar          (bar),
    .phase        (phase)
  );

  function automatic bit is_legal(input int bpm);
    foreach (legal_list[i]) if (legal_list[i] == bpm) return 1'b1;
    return 1'b0;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %0d (h%0h) expected %0d (h%0h) at %0t", name, got, got, want, want, $time);
    end
  endtask

  task automatic model_beat();
    m_phase = 0;
    m_beat  = 1'b1;
    m_idx   = (m_idx + 1) % BAR_LEN;
    m_bar   = (m_idx == 0);
  endtask

  // Reference behaviour, advanced once per rising edge from the sampled inputs.
  task automatic model_step();
    bit adopt;
    int w;
    m_beat = 1'b0;
    m_bar  = 1'b0;
    if (reset) begin
      m_tempo = 0; m_period = 0; m_phase = 0; m_idx = 0;
      m_cand = 0; m_agree = 0; m_locked = 1'b0;
      return;
    end
    adopt = 1'b0;
    if (tempo_valid && is_legal(int'(tempo_in))) begin
      if (int'(tempo_in) == m_cand) m_agree = (m_agree + 1 > AGREE_N) ? AGREE_N : m_agree + 1;
      else begin
        m_cand  = int'(tempo_in);
        m_agree = 1;
      end
      adopt = (m_agree == AGREE_N) && (m_cand != m_tempo);
    end
    if (adopt) begin
      m_tempo  = m_cand;
      m_period = (TICK_HZ * 60) / m_cand;
      m_locked = 1'b1;
      m_phase  = 0;
      m_idx    = 0;
    end else if (m_locked) begin
      w = m_period / 8;
      if (tick && m_phase == m_period - 1) model_beat();
      else if (onset && m_phase >= m_period - w) model_beat();
      else if (onset && m_phase >= 1 && m_phase <= w) m_phase = 0;
      else if (tick) m_phase++;
    end
  endtask

  always @(posedge clk) begin
    logic [25:0] want;
    model_step();
    #1;
    want = {m_tempo[7:0], m_locked, m_beat, m_idx[1:0], m_bar, m_phase[12:0]};
    checkOutput("cycle", {6'd0, tempo_locked, locked, beat, beat_index, bar, phase}, {6'd0, want});
  end

  task automatic applyStimulus(input logic t, input logic v, input logic [7:0] tp,
                               input logic o, input logic r);
    @(negedge clk);
    tick = t; tempo_valid = v; tempo_in = tp; onset = o; reset = r;
  endtask

  task automatic idle(input int n, input logic t);
    repeat (n) applyStimulus(t, 1'b0, 8'd0, 1'b0, 1'b0);
  endtask

  task automatic strobes(input int n, input logic [7:0] tp);
    repeat (n) applyStimulus(1'b0, 1'b1, tp, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    applyStimulus(1'b0, 1'b0, 8'd0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'd0, 1'b0, 1'b1);
  endtask

  // Ticks every cycle until a beat appears or the limit expires.
  task automatic run_ticks_until_beat(input int limit, output int n, output logic saw_bar);
    n = 0;
    saw_bar = 1'b0;
    while (n < limit) begin
      applyStimulus(1'b1, 1'b0, 8'd0, 1'b0, 1'b0);
      n++;
      @(posedge clk);
      #2;
      if (beat) begin
        saw_bar = bar;
        break;
      end
    end
  endtask

  initial begin
    #1_500_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    logic b;
    logic [7:0] cur;

    do_reset();
    idle(1, 1'b0);
    checkOutput("reset_state", {6'd0, tempo_locked, locked, beat, beat_index, bar, phase}, 32'd0);

    // Lock at 120, then four beats 3000 ticks apart with a bar on the fourth.
    strobes(4, 8'd120);
    idle(1, 1'b0);
    checkOutput("lock120_tempo", tempo_locked, 120);
    checkOutput("lock120_locked", locked, 1);
    checkOutput("lock120_phase", phase, 0);
    checkOutput("model_period120", m_period, 3000);
    for (int k = 0; k < 4; k++) begin
      run_ticks_until_beat(7000, n, b);
      checkOutput($sformatf("spacing120_%0d", k), n, 3000);
      checkOutput($sformatf("bar120_%0d", k), b, (k == 3) ? 1 : 0);
    end
    checkOutput("index_after_bar", beat_index, 0);

    // Mismatch restarts agreement.
    do_reset();
    strobes(2, 8'd120);
    strobes(1, 8'd90);
    strobes(2, 8'd120);
    idle(1, 1'b0);
    checkOutput("mismatch_locked", locked, 0);

    // Illegal tempo ignored.
    do_reset();
    strobes(4, 8'd100);
    idle(1, 1'b0);
    checkOutput("illegal_locked", locked, 0);
    checkOutput("illegal_tempo", tempo_locked, 0);
    checkOutput("model_agree_illegal", m_agree, 0);

    // Reset mid-beat at phase 2500, overriding tick and onset.
    strobes(4, 8'd120);
    idle(2500, 1'b1);
    applyStimulus(1'b1, 1'b0, 8'd0, 1'b1, 1'b1);
    checkOutput("pre_reset_phase", phase, 2500);
    idle(1, 1'b0);
    checkOutput("midbeat_reset", {6'd0, tempo_locked, locked, beat, beat_index, bar, phase}, 32'd0);
    strobes(3, 8'd120);
    idle(1, 1'b0);
    checkOutput("relock_after3", locked, 0);
    strobes(1, 8'd120);
    idle(1, 1'b0);
    checkOutput("relock_after4", locked, 1);

    // Retune 120 -> 180 on a tick cycle; next beat 2000 ticks later.
    run_ticks_until_beat(7000, n, b);
    checkOutput("spacing_before_retune", n, 3000);
    checkOutput("index_before_retune", beat_index, 1);
    idle(500, 1'b1);
    repeat (4) applyStimulus(1'b1, 1'b1, 8'd180, 1'b0, 1'b0);
    idle(1, 1'b0);
    checkOutput("retune_tempo", tempo_locked, 180);
    checkOutput("retune_phase", phase, 0);
    checkOutput("retune_index", beat_index, 0);
    checkOutput("retune_beat", beat, 0);
    run_ticks_until_beat(7000, n, b);
    checkOutput("spacing180", n, 2000);

    // Onset windows at 240 BPM (window 187).
    do_reset();
    strobes(4, 8'd240);
    idle(1400, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'd0, 1'b1, 1'b0);
    checkOutput("early_pre_phase", phase, 1400);
    idle(1, 1'b0);
    checkOutput("early_beat", beat, 1);
    checkOutput("early_phase", phase, 0);
    checkOutput("early_index", beat_index, 1);
    idle(100, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'd0, 1'b1, 1'b0);
    checkOutput("late_pre_phase", phase, 100);
    idle(1, 1'b0);
    checkOutput("late_phase", phase, 0);
    checkOutput("late_beat", beat, 0);
    idle(700, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'd0, 1'b1, 1'b0);
    idle(1, 1'b0);
    checkOutput("outside_phase", phase, 700);
    checkOutput("outside_beat", beat, 0);

    // Tick wrap and onset together at 60 BPM: one beat only.
    do_reset();
    strobes(4, 8'd60);
    idle(5999, 1'b1);
    applyStimulus(1'b1, 1'b0, 8'd0, 1'b1, 1'b0);
    checkOutput("wrap_pre_phase", phase, 5999);
    idle(1, 1'b0);
    checkOutput("wrap_beat", beat, 1);
    checkOutput("wrap_phase", phase, 0);
    idle(1, 1'b0);
    checkOutput("wrap_single_pulse", beat, 0);
    checkOutput("wrap_index", beat_index, 1);

    // Random traffic against the model.
    do_reset();
    cur = 8'd240;
    for (int i = 0; i < 15000; i++) begin
      if ($urandom_range(0, 5) == 0)
        cur = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(0, 255))
                                          : 8'(legal_list[$urandom_range(0, 5)]);
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, cur,
                    $urandom_range(0, 49) == 0, $urandom_range(0, 2999) == 0);
    end
    idle(2, 1'b0);
    @(posedge clk);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
